uart_cmd_regfile: RTL
=====================

UART_CMD_REGFILE -- requirements
Module: uart_cmd_regfile

Interface
REQ-001 Parameter NUM_REGS, default 8, number of registers; legal range 1..16.
REQ-002 Parameter REG_BYTES, default 4, bytes per register; legal range 1..4.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, maximum inter-byte gap allowed during a write; legal range 2..2^24-1.
REQ-004 clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 rx_valid  input  1  single-cycle strobe marking a received byte.
REQ-007 rx_data  input  8  received byte; valid only while rx_valid=1.
REQ-008 tx_busy  input  1  transmitter is busy sending the previous byte.
REQ-009 tx_enable  output  1  single-cycle request to send tx_data.
REQ-010 tx_data  output  8  byte to transmit; valid only while tx_enable=1.
REQ-011 reg_out  output  NUM_REGS*REG_BYTES*8  flattened register contents; register i occupies bits [i*REG_BYTES*8 +: REG_BYTES*8].
REQ-012 wr_strobe  output  1  single-cycle pulse on each register commit.
REQ-013 wr_index  output  4  index of the committed register; valid while wr_strobe=1.
REQ-014 err_count  output  8  saturating count of protocol errors.

Function
REQ-015 The command byte SHALL be decoded as: [7:6] opcode, where 01 = write, 10 = read, 11 = ping, 00 = illegal; [5:4] ignored; [3:0] register index.
REQ-016 Operation SHALL be controlled by an FSM with states IDLE, WR_DATA, WR_COMMIT, TX_LOAD, TX_HOLD and TX_WAIT.
REQ-017 IDLE, on rx_valid with a write command to index < NUM_REGS: the block SHALL latch the index, clear the byte counter and the gap timer, and go to WR_DATA.
REQ-018 WR_DATA, on each rx_valid: the block SHALL store the byte in a shadow buffer (least-significant byte first), increment the byte counter and clear the gap timer; after byte REG_BYTES it SHALL go to WR_COMMIT.
REQ-019 WR_COMMIT SHALL last one cycle: copy the shadow buffer into the register, pulse wr_strobe with wr_index, queue ack byte 0xAA, and go to TX_LOAD.
REQ-020 The register and reg_out SHALL update only in WR_COMMIT; a partial write SHALL never be visible.
REQ-021 In WR_DATA, when the gap timer reaches TIMEOUT_CYCLES with no rx_valid, the block SHALL discard the shadow buffer, increment err_count and return to IDLE; no byte is sent.
REQ-022 Read command, index < NUM_REGS: the block SHALL queue the REG_BYTES register bytes, least-significant first, snapshotted at the decode cycle, and go to TX_LOAD.
REQ-023 A ping command SHALL queue the single byte {NUM_REGS-1 [3:0], REG_BYTES-1 [1:0], 2'b00} and go to TX_LOAD.
REQ-024 An illegal opcode, or any index >= NUM_REGS, SHALL increment err_count, queue NAK byte 0xEE and go to TX_LOAD.
REQ-025 TX_LOAD SHALL wait until tx_busy=0, then assert tx_enable for exactly one cycle with the current queued byte and go to TX_HOLD.
REQ-026 TX_HOLD SHALL last one cycle with tx_busy ignored, then go to TX_WAIT.
REQ-027 TX_WAIT, once tx_busy=0: if more bytes remain, go to TX_LOAD; otherwise go to IDLE.
REQ-028 The response latency SHALL be: tx_enable asserted 1 cycle after the decode or commit cycle when tx_busy=0.
REQ-029 An rx_valid arriving in WR_COMMIT, TX_LOAD, TX_HOLD or TX_WAIT SHALL drop the byte and increment err_count.
REQ-030 err_count SHALL saturate at 255 and never wrap.
REQ-031 If an error increment coincides with a commit, both SHALL take effect in the same cycle.
REQ-032 tx_enable and wr_strobe SHALL never be asserted in the same cycle.
REQ-033 All state SHALL be held in registers; no output is combinationally dependent on rx_data.

Reset
REQ-034 While resetn=0 at a rising edge of clk, the block SHALL reset: FSM to IDLE; all registers, the shadow buffer and counters to 0; tx_enable=0, tx_data=0, wr_strobe=0, wr_index=0, err_count=0.
REQ-035 Reset asserted mid-write or mid-transmit SHALL abort the operation with no commit and no further tx_enable.
REQ-036 The first command after reset SHALL be accepted on the first cycle in which resetn=1 and rx_valid=1.

Verification
REQ-037 Defaults; send 0x43, 0x11, 0x22, 0x33, 0x44 -> one wr_strobe with wr_index=3, reg 3 = 0x44332211, then tx byte 0xAA.
REQ-038 After REQ-037, send 0x83 -> tx bytes 0x11, 0x22, 0x33, 0x44 in order, each tx_enable issued only while tx_busy=0.
REQ-039 Send 0x42, 0x55, then no further bytes for TIMEOUT_CYCLES -> no wr_strobe, reg 2 unchanged, err_count=1, FSM back in IDLE.
REQ-040 Send 0x89 with NUM_REGS=8, then 0x00 -> 0xEE sent after each command; err_count=2; no register modified.
REQ-041 Send 0xC0 -> tx byte 0x7C.
REQ-042 Hold tx_busy=1 during a read and inject rx_valid -> byte dropped, err_count increments; after 300 injected errors err_count=255; reset mid-read -> no further tx_enable.

Source files
------------

// File: rtl/uart_cmd_regfile.sv
// rtl/uart_cmd_regfile.sv - UART byte-command register file with write/read/ping and error counting
// One command byte per transaction; responses are queued LSB-first and paced by tx_busy.
module uart_cmd_regfile #(
  parameter int NUM_REGS       = 8,
  parameter int REG_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              rx_valid,
  input  logic [7:0]                        rx_data,
  input  logic                              tx_busy,
  output logic                              tx_enable,
  output logic [7:0]                        tx_data,
  output logic [NUM_REGS*REG_BYTES*8-1:0]   reg_out,
  output logic                              wr_strobe,
  output logic [3:0]                        wr_index,
  output logic [7:0]                        err_count
);

  localparam int W = REG_BYTES * 8;
  localparam logic [7:0] ACK_BYTE  = 8'hAA;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;
  localparam logic [7:0] PING_BYTE = {4'(NUM_REGS - 1), 2'(REG_BYTES - 1), 2'b00};

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_COMMIT, TX_LOAD, TX_HOLD, TX_WAIT} state_t;

  state_t       state;
  logic [W-1:0] regs [NUM_REGS];
  logic [W-1:0] shadow;
  logic [W-1:0] shadow_shift;
  logic [W-1:0] q_buf;
  logic [W-1:0] rd_val;
  logic [2:0]   byte_cnt;
  logic [2:0]   q_rem;
  logic [3:0]   idx;
  logic [23:0]  gap;
  logic [1:0]   opcode;
  logic [3:0]   cmd_idx;
  logic         idx_ok;
  logic         gap_expired;
  logic         err_event;

  assign opcode       = rx_data[7:6];
  assign cmd_idx      = rx_data[3:0];
  assign idx_ok       = {1'b0, cmd_idx} < 5'(NUM_REGS);
  assign gap_expired  = gap == 24'(TIMEOUT_CYCLES - 1);
  // Bytes enter at the top and shift down, so the first byte ends up least significant.
  assign shadow_shift = W'({rx_data, shadow} >> 8);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_idx == 4'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    err_event = 1'b0;
    case (state)
      IDLE:    err_event = rx_valid && (opcode == 2'b00 || (opcode != 2'b11 && !idx_ok));
      WR_DATA: err_event = !rx_valid && gap_expired;
      default: err_event = rx_valid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      shadow    <= '0;
      q_buf     <= '0;
      byte_cnt  <= '0;
      q_rem     <= '0;
      idx       <= '0;
      gap       <= '0;
      tx_enable <= 1'b0;
      tx_data   <= '0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      tx_enable <= 1'b0;
      wr_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            q_rem <= 3'd1;
            if (opcode == 2'b01 && idx_ok) begin
              idx      <= cmd_idx;
              byte_cnt <= '0;
              gap      <= '0;
              state    <= WR_DATA;
            end else if (opcode == 2'b10 && idx_ok) begin
              q_buf <= rd_val;
              q_rem <= 3'(REG_BYTES);
              state <= TX_LOAD;
            end else if (opcode == 2'b11) begin
              q_buf <= W'(PING_BYTE);
              state <= TX_LOAD;
            end else begin
              q_buf <= W'(NAK_BYTE);
              state <= TX_LOAD;
            end
          end
        end
        WR_DATA: begin
          if (rx_valid) begin
            shadow   <= shadow_shift;
            gap      <= '0;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'(REG_BYTES - 1)) state <= WR_COMMIT;
          end else if (gap_expired) begin
            shadow <= '0;
            state  <= IDLE;
          end else begin
            gap <= gap + 24'd1;
          end
        end
        WR_COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) regs[i] <= shadow;
          end
          wr_strobe <= 1'b1;
          wr_index  <= idx;
          q_buf     <= W'(ACK_BYTE);
          q_rem     <= 3'd1;
          state     <= TX_LOAD;
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_enable <= 1'b1;
            tx_data   <= q_buf[7:0];
            q_buf     <= q_buf >> 8;
            q_rem     <= q_rem - 3'd1;
            state     <= TX_HOLD;
          end
        end
        TX_HOLD: state <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy) state <= (q_rem == 3'd0) ? IDLE : TX_LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Kept apart from the FSM so an error and a commit can land in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (err_event && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*W +: W] = regs[g];
  end

endmodule
